// File: rtl/tnn_vote_counter_if.sv
// Comparator-beat input stream and classification-result output of the vote counter.
// slave is the counter side; master is the producer/consumer side.
interface tnn_vote_counter_if #(
  parameter int NUM_CLASSES     = 7,
  parameter int VOTES_PER_CLASS = 8
);
  localparam int CNT_W = $clog2(VOTES_PER_CLASS + 1);
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic             cmp_valid;
  logic             cmp_bit;
  logic             cmp_ready;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_class;
  logic [CNT_W-1:0] out_score;

  modport master (
    output cmp_valid, cmp_bit, out_ready,
    input  cmp_ready, out_valid, out_class, out_score
  );

  modport slave (
    input  cmp_valid, cmp_bit, out_ready,
    output cmp_ready, out_valid, out_class, out_score
  );
endinterface

// File: rtl/tnn_vote_counter.sv
// Accumulates class-major comparator votes, then scans one class per cycle for the
// highest count (ties keep the lowest index) and holds the result until accepted.
module tnn_vote_counter #(
  parameter int NUM_CLASSES     = 7,
  parameter int VOTES_PER_CLASS = 8
) (
  input logic               clk,
  input logic               rst,
  tnn_vote_counter_if.slave bus
);
  localparam int CNT_W = $clog2(VOTES_PER_CLASS + 1);
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int VID_W = (VOTES_PER_CLASS > 1) ? $clog2(VOTES_PER_CLASS) : 1;
  localparam logic [VID_W-1:0] LAST_VOTE = VID_W'(VOTES_PER_CLASS - 1);
  localparam logic [IDX_W-1:0] LAST_CLS  = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
  logic [VID_W-1:0] vote_idx_q, vote_idx_d;
  logic [IDX_W-1:0] cls_idx_q, cls_idx_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] best_cls_q, best_cls_d;
  logic [CNT_W-1:0] best_score_q, best_score_d;
  logic [IDX_W-1:0] out_class_q, out_class_d;
  logic [CNT_W-1:0] out_score_q, out_score_d;
  logic [CNT_W-1:0] scan_cnt;
  logic             take;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vote_idx_d   = vote_idx_q;
    cls_idx_d    = cls_idx_q;
    scan_idx_d   = scan_idx_q;
    best_cls_d   = best_cls_q;
    best_score_d = best_score_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
    scan_cnt     = cnt_q[scan_idx_q];
    // Index 0 always seeds the running best; later classes must strictly beat it.
    take         = (scan_idx_q == '0) || (scan_cnt > best_score_q);

    case (state_q)
      ACCUM: begin
        if (bus.cmp_valid) begin
          if (bus.cmp_bit) begin
            cnt_d[cls_idx_q] = cnt_q[cls_idx_q] + CNT_W'(1);
          end
          if (vote_idx_q == LAST_VOTE) begin
            vote_idx_d = '0;
            if (cls_idx_q == LAST_CLS) begin
              cls_idx_d  = '0;
              scan_idx_d = '0;
              state_d    = SCAN;
            end else begin
              cls_idx_d = cls_idx_q + IDX_W'(1);
            end
          end else begin
            vote_idx_d = vote_idx_q + VID_W'(1);
          end
        end
      end
      SCAN: begin
        if (take) begin
          best_cls_d   = scan_idx_q;
          best_score_d = scan_cnt;
        end
        if (scan_idx_q == LAST_CLS) begin
          out_class_d = best_cls_d;
          out_score_d = best_score_d;
          state_d     = OUT;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          for (int i = 0; i < NUM_CLASSES; i++) cnt_d[i] = '0;
          vote_idx_d = '0;
          cls_idx_d  = '0;
          state_d    = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
      vote_idx_q   <= '0;
      cls_idx_q    <= '0;
      scan_idx_q   <= '0;
      best_cls_q   <= '0;
      best_score_q <= '0;
      out_class_q  <= '0;
      out_score_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vote_idx_q   <= vote_idx_d;
      cls_idx_q    <= cls_idx_d;
      scan_idx_q   <= scan_idx_d;
      best_cls_q   <= best_cls_d;
      best_score_q <= best_score_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
    end
  end

  assign bus.cmp_ready = (state_q == ACCUM);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_class = out_class_q;
  assign bus.out_score = out_score_q;
endmodule

// File: tb/tb_tnn_vote_counter.sv
// Randomized bench for tnn_vote_counter: each sample's winner is predicted from
// per-class vote sums and compared with the DUT result, latency and handshake.
module tb_tnn_vote_counter;
  localparam int NC    = 7;
  localparam int VPC   = 8;
  localparam int TOTAL = NC * VPC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tnn_vote_counter_if #(.NUM_CLASSES(NC), .VOTES_PER_CLASS(VPC)) bus ();
  tnn_vote_counter #(.NUM_CLASSES(NC), .VOTES_PER_CLASS(VPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic votes [TOTAL];
  int   exp_cls, exp_score;

  // Reference: per-class sums, first maximum wins.
  function automatic void model();
    int sums [NC];
    for (int c = 0; c < NC; c++) sums[c] = 0;
    for (int i = 0; i < TOTAL; i++) if (votes[i]) sums[i / VPC]++;
    exp_cls   = 0;
    exp_score = sums[0];
    for (int c = 1; c < NC; c++) begin
      if (sums[c] > exp_score) begin
        exp_cls   = c;
        exp_score = sums[c];
      end
    end
  endfunction

  task automatic fill_random(input int pct);
    for (int i = 0; i < TOTAL; i++) votes[i] = ($urandom_range(99) < pct);
  endtask

  task automatic fill_class(input int cls);
    for (int i = 0; i < TOTAL; i++) votes[i] = ((i / VPC) == cls);
  endtask

  // Streams votes[0..nbeats-1]; returns with the final beat presented, to be taken at the next edge.
  task automatic drive(input int nbeats, input int gap_pct);
    int sent  = 0;
    int guard = 0;
    while (sent < nbeats && guard < 2000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(99) < gap_pct) begin
        bus.cmp_valid = 1'b0;
        bus.cmp_bit   = 1'($urandom_range(1));
      end else begin
        bus.cmp_valid = 1'b1;
        bus.cmp_bit   = votes[sent];
        if (bus.cmp_ready) sent++;
      end
    end
  endtask

  // Cycles from the final beat's cycle to the first out_valid; -1 on timeout.
  task automatic await_out(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus.cmp_valid = 1'b0;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmp_valid = 1'b0;
    bus.cmp_bit   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.cmp_ready !== 1'b1) $display("FAIL reset_cmp_ready: got %0b want 1", bus.cmp_ready); else pass_cnt++;
    total_cnt++; if (bus.out_class !== 3'd0) $display("FAIL reset_out_class: got %0d want 0", bus.out_class); else pass_cnt++;
    total_cnt++; if (bus.out_score !== 4'd0) $display("FAIL reset_out_score: got %0d want 0", bus.out_score); else pass_cnt++;
  endtask

  task automatic run_sample(input string name, input int gap_pct);
    int lat;
    model();
    drive(TOTAL, gap_pct);
    await_out(lat);
    total_cnt++; if (lat !== NC + 1) $display("FAIL %s_latency: got %0d want %0d", name, lat, NC + 1); else pass_cnt++;
    total_cnt++; if (bus.out_class !== 3'(exp_cls)) $display("FAIL %s_class: got %0d want %0d", name, bus.out_class, exp_cls); else pass_cnt++;
    total_cnt++; if (bus.out_score !== 4'(exp_score)) $display("FAIL %s_score: got %0d want %0d", name, bus.out_score, exp_score); else pass_cnt++;
  endtask

  task automatic release_result(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL %s_valid_drop: got %0b want 0", name, bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.cmp_ready !== 1'b1) $display("FAIL %s_ready_back: got %0b want 1", name, bus.cmp_ready); else pass_cnt++;
  endtask

  task automatic test_single_class();
    fill_class(3);
    run_sample("class3", 0);
    release_result("class3");
  endtask

  task automatic test_tie();
    int k, placed, p;
    for (int i = 0; i < TOTAL; i++) votes[i] = 1'b0;
    for (int c = 0; c < NC; c++) begin
      k = (c == 1 || c == 5) ? 5 : 2;
      placed = 0;
      while (placed < k) begin
        p = $urandom_range(VPC - 1);
        if (!votes[c * VPC + p]) begin
          votes[c * VPC + p] = 1'b1;
          placed++;
        end
      end
    end
    run_sample("tie", 0);
    release_result("tie");
  endtask

  task automatic test_zero_gaps();
    fill_random(0);
    run_sample("zero_gaps", 40);
    release_result("zero_gaps");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_random(int'($urandom_range(10, 90)));
      run_sample("random", 30);
      release_result("random");
    end
  endtask

  task automatic test_hold();
    fill_random(50);
    run_sample("hold", 20);
    for (int n = 0; n < 5; n++) begin
      bus.cmp_valid = 1'b1;
      bus.cmp_bit   = 1'b1;
      @(negedge clk);
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.cmp_ready !== 1'b0) $display("FAIL hold_flags: got valid=%0b ready=%0b want 1/0", bus.out_valid, bus.cmp_ready); else pass_cnt++;
      total_cnt++; if (bus.out_class !== 3'(exp_cls) || bus.out_score !== 4'(exp_score)) $display("FAIL hold_stable: got %0d/%0d want %0d/%0d", bus.out_class, bus.out_score, exp_cls, exp_score); else pass_cnt++;
    end
    bus.cmp_valid = 1'b0;
    release_result("hold");
    fill_random(0);
    run_sample("after_hold", 0);
    release_result("after_hold");
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int i = 0; i < TOTAL; i++) votes[i] = 1'b1;
    drive(20, 10);
    @(negedge clk);
    bus.cmp_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL midreset_no_result: got %0d valid cycles want 0", seen); else pass_cnt++;
    total_cnt++; if (bus.out_class !== 3'd0 || bus.out_score !== 4'd0) $display("FAIL midreset_outputs: got %0d/%0d want 0/0", bus.out_class, bus.out_score); else pass_cnt++;
    fill_class(6);
    run_sample("class6", 0);
    // Reset together with an accepting out_ready while the result is pending.
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.cmp_ready !== 1'b1) $display("FAIL outreset_flags: got valid=%0b ready=%0b want 0/1", bus.out_valid, bus.cmp_ready); else pass_cnt++;
    total_cnt++; if (bus.out_class !== 3'd0 || bus.out_score !== 4'd0) $display("FAIL outreset_outputs: got %0d/%0d want 0/0", bus.out_class, bus.out_score); else pass_cnt++;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL outreset_no_result: got %0d valid cycles want 0", seen); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    fill_random(60);
    run_sample("b2b_first", 0);
    fill_random(40);
    run_sample("b2b_second", 0);
    @(negedge clk);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_two_results: got valid=%0b want 0", bus.out_valid); else pass_cnt++;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_class();
    test_tie();
    test_zero_gaps();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
